// File: rtl/i2c_target.sv
// I2C target core: oversampled SCL/SDA, 7-bit address match, byte-wide write/read handshake.
// SDA is open-drain through ck_sda_oe; SCL is only sampled, never stretched.
module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned HOLD_CYCLES = 30
) (
    input  logic       clk100,
    input  logic       reset_n,
    input  logic       ck_scl,
    input  logic       ck_sda_i,
    output logic       ck_sda_oe,
    output logic       start_p,
    output logic       stop_p,
    output logic       addr_match,
    output logic       rw,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       ack_in_progress
);

    localparam logic [3:0] FiltMax  = 4'(FILTER_LEN - 1);
    localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        StIdle, StAddr, StIgnore, StAddrAck, StWrite, StWriteAck, StRead, StReadAck
    } state_e;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic [1:0]             r_filt, r_filt_d;  // bit 0 = SCL, bit 1 = SDA
    logic [1:0][3:0]        r_fcnt;
    logic [7:0]             r_hold;
    logic [1:0]             w_raw;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop, w_sda, w_hold_done;

    state_e     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_nxt;
    logic [6:0] r_shift, w_shift_nxt;
    logic [7:0] r_tx, w_tx_nxt;
    logic       r_oe, w_oe_nxt;
    logic       r_ack, w_ack_nxt;
    logic       r_phase, w_phase_nxt;
    logic       r_ack_ok, w_ack_ok_nxt;
    logic       r_match, w_match_nxt;
    logic       r_rw, w_rw_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic       r_wr_valid, w_wr_valid_nxt;
    logic       r_rd_req, w_rd_req_nxt;
    logic       r_start_p, r_stop_p;
    logic [1:0] r_req_d;

    assign w_raw       = {r_sda_sync[SYNC_STAGES-1], r_scl_sync[SYNC_STAGES-1]};
    assign w_scl_rise  = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall  = ~r_filt[0] & r_filt_d[0];
    assign w_start     = r_filt[0] & r_filt_d[0] & ~r_filt[1] & r_filt_d[1];
    assign w_stop      = r_filt[0] & r_filt_d[0] & r_filt[1] & ~r_filt_d[1];
    assign w_sda       = r_filt[1];
    assign w_hold_done = (r_hold == 8'd1);

    // Input synchronizers, stability filters and the SCL-fall hold timer.
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_filt     <= 2'b11;
            r_filt_d   <= 2'b11;
            r_fcnt     <= '0;
            r_hold     <= '0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], ck_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], ck_sda_i};
            r_filt_d   <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (w_raw[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FiltMax) begin
                    r_filt[i] <= w_raw[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 4'd1;
                end
            end
            if (w_scl_fall) begin
                r_hold <= HoldInit;
            end else if (r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_oe       <= 1'b0;
            r_ack      <= 1'b0;
            r_phase    <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_match    <= 1'b0;
            r_rw       <= 1'b0;
            r_wr_data  <= '0;
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
            r_start_p  <= 1'b0;
            r_stop_p   <= 1'b0;
            r_req_d    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_oe       <= w_oe_nxt;
            r_ack      <= w_ack_nxt;
            r_phase    <= w_phase_nxt;
            r_ack_ok   <= w_ack_ok_nxt;
            r_match    <= w_match_nxt;
            r_rw       <= w_rw_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_rd_req   <= w_rd_req_nxt;
            r_start_p  <= w_start & ~w_stop;
            r_stop_p   <= w_stop;
            r_req_d    <= {r_req_d[0], r_rd_req};
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_oe_nxt       = r_oe;
        w_ack_nxt      = r_ack;
        w_phase_nxt    = r_phase;
        w_ack_ok_nxt   = r_ack_ok;
        w_match_nxt    = r_match;
        w_rw_nxt       = r_rw;
        w_wr_data_nxt  = r_wr_data;
        w_wr_valid_nxt = 1'b0;
        w_rd_req_nxt   = 1'b0;
        if (r_req_d[1]) begin
            w_tx_nxt = rd_data;
        end
        unique case (r_state)
            StIdle, StIgnore: ;
            StAddr: begin
                if (w_scl_rise) begin
                    w_shift_nxt = {r_shift[5:0], w_sda};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_shift == TARGET_ADDR) begin
                            w_rw_nxt    = w_sda;
                            w_phase_nxt = 1'b0;
                            w_state_nxt = StAddrAck;
                        end else begin
                            w_state_nxt = StIgnore;
                        end
                    end
                end
            end
            // First hold point (after the 8th fall) drives the ACK, second one ends the slot.
            StAddrAck, StWriteAck: begin
                if (w_hold_done) begin
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        if (r_state == StAddrAck) begin
                            w_oe_nxt     = 1'b1;
                            w_ack_nxt    = 1'b1;
                            w_match_nxt  = 1'b1;
                            w_rd_req_nxt = r_rw;
                        end else if (r_ack_ok) begin
                            w_oe_nxt  = 1'b1;
                            w_ack_nxt = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = 1'b0;
                        w_oe_nxt    = 1'b0;
                        w_ack_nxt   = 1'b0;
                        w_bit_nxt   = '0;
                        if (r_state == StWriteAck) begin
                            w_state_nxt = r_ack_ok ? StWrite : StIgnore;
                        end else if (!r_rw) begin
                            w_state_nxt = StWrite;
                        end else begin
                            w_state_nxt = StRead;
                            w_oe_nxt    = ~r_tx[7];
                            w_tx_nxt    = {r_tx[6:0], 1'b0};
                        end
                    end
                end
            end
            StWrite: begin
                if (w_scl_rise) begin
                    w_shift_nxt = {r_shift[5:0], w_sda};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_wr_data_nxt  = {r_shift, w_sda};
                        w_wr_valid_nxt = wr_ready;
                        w_ack_ok_nxt   = wr_ready;
                        w_phase_nxt    = 1'b0;
                        w_state_nxt    = StWriteAck;
                    end
                end
            end
            StRead: begin
                if (w_hold_done) begin
                    w_oe_nxt = ~r_tx[7];
                    w_tx_nxt = {r_tx[6:0], 1'b0};
                end
                if (w_scl_rise) begin
                    w_bit_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = StReadAck;
                    end
                end
            end
            StReadAck: begin
                if (w_hold_done) begin
                    w_oe_nxt = 1'b0;
                end
                if (w_scl_rise) begin
                    w_bit_nxt = '0;
                    if (!w_sda) begin
                        w_rd_req_nxt = 1'b1;
                        w_state_nxt  = StRead;
                    end else begin
                        w_state_nxt = StIgnore;
                    end
                end
            end
        endcase
        // STOP takes priority over START if both ever coincide.
        if (w_stop || w_start) begin
            w_state_nxt    = w_stop ? StIdle : StAddr;
            w_bit_nxt      = '0;
            w_oe_nxt       = 1'b0;
            w_ack_nxt      = 1'b0;
            w_phase_nxt    = 1'b0;
            w_match_nxt    = 1'b0;
            w_wr_valid_nxt = 1'b0;
            w_rd_req_nxt   = 1'b0;
        end
    end

    assign ck_sda_oe       = r_oe;
    assign start_p         = r_start_p;
    assign stop_p          = r_stop_p;
    assign addr_match      = r_match;
    assign rw              = r_rw;
    assign wr_data         = r_wr_data;
    assign wr_valid        = r_wr_valid;
    assign rd_req          = r_rd_req;
    assign ack_in_progress = r_ack;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-level I2C controller plus a transaction-level
// reference of what the target must ACK, deliver and return.
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int FLEN = 4;
    localparam int Q = 30;  // quarter SCL period in clk100 cycles

    logic       clk100 = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_ctl = 1'b1;
    logic       wr_ready = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       sda_bus;
    logic       ck_sda_oe, start_p, stop_p, addr_match, rw, wr_valid, rd_req, ack_in_progress;
    logic [7:0] wr_data;

    int n_tests = 0;
    int n_fail = 0;
    int n_start, n_stop, n_rdreq, n_oe_cyc, n_viol;
    logic [7:0] wr_got[$];
    logic [7:0] rd_q[$];
    logic prev_oe = 1'b0;

    assign sda_bus = sda_ctl & ~ck_sda_oe;

    always #5 clk100 = ~clk100;

    i2c_target #(
        .TARGET_ADDR(ADDR), .SYNC_STAGES(2), .FILTER_LEN(FLEN), .HOLD_CYCLES(30)
    ) dut (
        .clk100(clk100), .reset_n(reset_n), .ck_scl(scl), .ck_sda_i(sda_bus),
        .ck_sda_oe(ck_sda_oe), .start_p(start_p), .stop_p(stop_p), .addr_match(addr_match),
        .rw(rw), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_req(rd_req),
        .rd_data(rd_data), .ack_in_progress(ack_in_progress)
    );

    // Bus monitor and read-data responder.
    initial forever begin
        @(negedge clk100);
        if (start_p) n_start++;
        if (stop_p) n_stop++;
        if (wr_valid) wr_got.push_back(wr_data);
        if (rd_req) begin
            n_rdreq++;
            if (rd_q.size() > 0) rd_data = rd_q.pop_front();
        end
        if (ck_sda_oe) n_oe_cyc++;
        if (ck_sda_oe !== prev_oe && scl) n_viol++;
        if (ack_in_progress && !ck_sda_oe) n_viol++;
        prev_oe = ck_sda_oe;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic clr();
        n_start = 0; n_stop = 0; n_rdreq = 0; n_oe_cyc = 0; n_viol = 0;
        wr_got.delete();
        rd_q.delete();
    endtask

    function automatic logic [7:0] wr_at(input int i);
        return (i < wr_got.size()) ? wr_got[i] : 8'hxx;
    endfunction

    task automatic bus_start();
        sda_ctl = 1'b1; cyc(Q); scl = 1'b1; cyc(Q); sda_ctl = 1'b0; cyc(Q); scl = 1'b0; cyc(Q);
    endtask

    task automatic bus_stop();
        sda_ctl = 1'b0; cyc(Q); scl = 1'b1; cyc(Q); sda_ctl = 1'b1; cyc(2 * Q);
    endtask

    task automatic bit_xfer(input logic b, output logic obs);
        sda_ctl = b; cyc(Q); scl = 1'b1; cyc(Q); obs = sda_bus; cyc(Q); scl = 1'b0; cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic t;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], t);
        bit_xfer(1'b1, t);
        ack = ~t;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, t);
            b[i] = t;
        end
        bit_xfer(~ack, t);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(5);
        n_tests++;
        if ({ck_sda_oe, start_p, stop_p, addr_match, rw, wr_valid, rd_req, ack_in_progress} !== 8'h00)
        begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000000", {ck_sda_oe, start_p, stop_p,
                     addr_match, rw, wr_valid, rd_req, ack_in_progress});
        end
        n_tests++;
        if (wr_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data);
        end
        reset_n = 1'b1;
        clr();
        cyc(20);
        n_tests++;
        if (n_start + n_stop + n_oe_cyc !== 0) begin
            n_fail++; $display("FAIL reset_idle_quiet: got %0d events want 0", n_start + n_stop + n_oe_cyc);
        end
    endtask

    task automatic test_write();
        logic a0, a1, a2, am, rwv;
        clr();
        bus_start();
        write_byte({ADDR, 1'b0}, a0);
        write_byte(8'hA5, a1);
        write_byte(8'h3C, a2);
        am = addr_match;
        rwv = rw;
        bus_stop();
        cyc(20);
        n_tests++;
        if ({a0, a1, a2} !== 3'b111) begin
            n_fail++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2});
        end
        n_tests++;
        if (am !== 1'b1 || rwv !== 1'b0) begin
            n_fail++; $display("FAIL write_match_rw: got match=%b rw=%b want 1/0", am, rwv);
        end
        n_tests++;
        if (wr_got.size() !== 2 || wr_at(0) !== 8'hA5 || wr_at(1) !== 8'h3C) begin
            n_fail++;
            $display("FAIL write_data: got n=%0d %h %h want n=2 a5 3c", wr_got.size(), wr_at(0), wr_at(1));
        end
        n_tests++;
        if (n_stop !== 1 || n_start !== 1 || addr_match !== 1'b0) begin
            n_fail++;
            $display("FAIL write_start_stop: got start=%0d stop=%0d match=%b want 1/1/0", n_start,
                     n_stop, addr_match);
        end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        clr();
        bus_start();
        write_byte({7'h43, 1'b0}, a0);
        write_byte(8'($urandom), a1);
        bus_stop();
        cyc(20);
        n_tests++;
        if (a0 !== 1'b0 || a1 !== 1'b0 || n_oe_cyc !== 0) begin
            n_fail++;
            $display("FAIL wrong_addr_nack: got ack=%b%b oe_cycles=%0d want 00/0", a0, a1, n_oe_cyc);
        end
        n_tests++;
        if (wr_got.size() !== 0 || addr_match !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_addr_quiet: got wr=%0d match=%b want 0/0", wr_got.size(), addr_match);
        end
    endtask

    task automatic test_read();
        logic a0, oe_after, rwv;
        logic [7:0] b0, b1;
        clr();
        rd_q.push_back(8'h96);
        rd_q.push_back(8'h01);
        bus_start();
        write_byte({ADDR, 1'b1}, a0);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        oe_after = ck_sda_oe;
        rwv = rw;
        bus_stop();
        cyc(20);
        n_tests++;
        if (a0 !== 1'b1 || rwv !== 1'b1) begin
            n_fail++; $display("FAIL read_addr: got ack=%b rw=%b want 1/1", a0, rwv);
        end
        n_tests++;
        if (b0 !== 8'h96 || b1 !== 8'h01) begin
            n_fail++; $display("FAIL read_data: got %h %h want 96 01", b0, b1);
        end
        n_tests++;
        if (n_rdreq !== 2 || oe_after !== 1'b0 || n_viol !== 0) begin
            n_fail++;
            $display("FAIL read_handshake: got rd_req=%0d oe=%b viol=%0d want 2/0/0", n_rdreq,
                     oe_after, n_viol);
        end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2, rw0, rw1;
        int s_mid, p_mid;
        logic [7:0] b;
        clr();
        bus_start();
        write_byte({ADDR, 1'b0}, a0);
        write_byte(8'h10, a1);
        rw0 = rw;
        rd_q.push_back(8'h77);
        bus_start();
        s_mid = n_start;
        p_mid = n_stop;
        write_byte({ADDR, 1'b1}, a2);
        read_byte(1'b0, b);
        rw1 = rw;
        bus_stop();
        cyc(20);
        n_tests++;
        if ({a0, a1, a2} !== 3'b111 || s_mid !== 2 || p_mid !== 0) begin
            n_fail++;
            $display("FAIL rs_framing: got acks=%b start=%0d stop=%0d want 111/2/0", {a0, a1, a2},
                     s_mid, p_mid);
        end
        n_tests++;
        if (rw0 !== 1'b0 || rw1 !== 1'b1) begin
            n_fail++; $display("FAIL rs_rw: got %b then %b want 0 then 1", rw0, rw1);
        end
        n_tests++;
        if (b !== 8'h77 || wr_got.size() !== 1 || wr_at(0) !== 8'h10) begin
            n_fail++;
            $display("FAIL rs_data: got rd=%h wr_n=%0d wr=%h want 77/1/10", b, wr_got.size(), wr_at(0));
        end
    endtask

    task automatic test_wr_ready_nack();
        logic a0, a1, a2;
        clr();
        bus_start();
        write_byte({ADDR, 1'b0}, a0);
        write_byte(8'h5A, a1);
        wr_ready = 1'b0;
        write_byte(8'hC3, a2);
        wr_ready = 1'b1;
        bus_stop();
        cyc(20);
        n_tests++;
        if ({a0, a1, a2} !== 3'b110) begin
            n_fail++; $display("FAIL ready_acks: got %b want 110", {a0, a1, a2});
        end
        n_tests++;
        if (wr_got.size() !== 1 || wr_at(0) !== 8'h5A) begin
            n_fail++; $display("FAIL ready_valid: got n=%0d %h want n=1 5a", wr_got.size(), wr_at(0));
        end
    endtask

    task automatic test_glitch_reset();
        logic a, t, oe_pre, oe_post;
        clr();
        repeat (4) begin
            sda_ctl = 1'b0; cyc(FLEN - 1); sda_ctl = 1'b1; cyc(10);
        end
        n_tests++;
        if (n_start !== 0 || n_stop !== 0) begin
            n_fail++; $display("FAIL glitch_idle: got start=%0d stop=%0d want 0/0", n_start, n_stop);
        end
        sda_ctl = 1'b0;
        cyc(Q);
        repeat (4) begin
            sda_ctl = 1'b1; cyc(FLEN - 1); sda_ctl = 1'b0; cyc(8);
        end
        scl = 1'b0;
        cyc(Q);
        write_byte({ADDR, 1'b0}, a);
        n_tests++;
        if (n_start !== 1 || n_stop !== 0 || a !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy: got start=%0d stop=%0d ack=%b want 1/0/1", n_start, n_stop, a);
        end
        bus_stop();
        // Reset in the middle of a read bit that drives SDA low.
        rd_q.push_back(8'h00);
        bus_start();
        write_byte({ADDR, 1'b1}, a);
        repeat (3) bit_xfer(1'b1, t);
        sda_ctl = 1'b1;
        cyc(Q);
        oe_pre = ck_sda_oe;
        reset_n = 1'b0;
        cyc(1);
        oe_post = ck_sda_oe;
        cyc(2);
        reset_n = 1'b1;
        n_start = 0; n_stop = 0; n_oe_cyc = 0;
        scl = 1'b1; cyc(2 * Q); scl = 1'b0; cyc(Q);
        repeat (5) bit_xfer(1'b1, t);
        n_tests++;
        if (oe_pre !== 1'b1 || oe_post !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got oe before=%b after=%b want 1/0", oe_pre, oe_post);
        end
        n_tests++;
        if (n_start !== 0 || n_stop !== 0 || n_oe_cyc !== 0) begin
            n_fail++;
            $display("FAIL reset_ignore: got start=%0d stop=%0d oe_cycles=%0d want 0/0/0", n_start,
                     n_stop, n_oe_cyc);
        end
        bus_stop();
        cyc(10);
    endtask

    task automatic test_random();
        logic [6:0] a7;
        logic dir, match, a, alive, rdy, exp_ack, last;
        int len, exp_req;
        logic [7:0] d, b, exp_b;
        logic [7:0] exp_wr[$];
        logic [7:0] exp_rd[$];
        for (int t = 0; t < 5; t++) begin
            a7 = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
            if (a7 == ADDR && $urandom_range(0, 3) == 0) a7 = ADDR ^ 7'h01;
            dir = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2);
            match = (a7 == ADDR);
            clr();
            exp_wr.delete();
            exp_rd.delete();
            if (dir && match) begin
                for (int j = 0; j < len; j++) begin
                    d = 8'($urandom);
                    rd_q.push_back(d);
                    exp_rd.push_back(d);
                end
            end
            bus_start();
            write_byte({a7, dir}, a);
            n_tests++;
            if (a !== match) begin
                n_fail++; $display("FAIL rand_addr_ack: addr=%h got %b want %b", a7, a, match);
            end
            alive = match;
            for (int j = 0; j < len; j++) begin
                if (!dir) begin
                    d = 8'($urandom);
                    rdy = ($urandom_range(0, 3) != 0);
                    wr_ready = rdy;
                    write_byte(d, a);
                    exp_ack = alive && rdy;
                    if (exp_ack) exp_wr.push_back(d);
                    alive = exp_ack;
                    n_tests++;
                    if (a !== exp_ack) begin
                        n_fail++; $display("FAIL rand_wr_ack: byte %0d got %b want %b", j, a, exp_ack);
                    end
                end else begin
                    last = (j == len - 1);
                    read_byte(~last, b);
                    exp_b = match ? exp_rd[j] : 8'hFF;
                    n_tests++;
                    if (b !== exp_b) begin
                        n_fail++; $display("FAIL rand_rd_data: byte %0d got %h want %h", j, b, exp_b);
                    end
                end
            end
            wr_ready = 1'b1;
            bus_stop();
            cyc(10);
            exp_req = (dir && match) ? len : 0;
            n_tests++;
            if (n_rdreq !== exp_req || wr_got.size() !== exp_wr.size() || n_viol !== 0) begin
                n_fail++;
                $display("FAIL rand_counts: got rd_req=%0d wr=%0d viol=%0d want %0d/%0d/0", n_rdreq,
                         wr_got.size(), n_viol, exp_req, exp_wr.size());
            end
            for (int j = 0; j < exp_wr.size(); j++) begin
                n_tests++;
                if (wr_at(j) !== exp_wr[j]) begin
                    n_fail++; $display("FAIL rand_wr_data: byte %0d got %h want %h", j, wr_at(j), exp_wr[j]);
                end
            end
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_repeated_start();
        test_wr_ready_nack();
        test_glitch_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
